// File: rtl/pipe_elastic_reg_pkg.sv
// pipe_elastic_reg_pkg: shared pipeline-stage types and constants.
//   pipe_ctrl_t  - 2-bit stage control (RUN / FLUSH / HOLD / HOLD_ALT)
//   PERF_CNT_W   - width of the optional performance counters
//   ptr_width()  - pointer width for a DEPTH-entry circular buffer
package pipe_elastic_reg_pkg;

    typedef enum logic [1:0] {
        PIPE_RUN      = 2'b00,
        PIPE_FLUSH    = 2'b01,
        PIPE_HOLD     = 2'b10,
        PIPE_HOLD_ALT = 2'b11
    } pipe_ctrl_t;

    localparam int PERF_CNT_W = 32;

    // A single-entry buffer still needs a one-bit pointer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_elastic_reg_wrap_ptr.sv
// pipe_wrap_ptr: modulo-DEPTH pointer with increment and clear.
//   clk   - clock
//   reset - synchronous active-low reset, clears the pointer
//   i_inc - advance the pointer by one, wrapping DEPTH-1 -> 0
//   i_clr - clear the pointer to 0 (takes priority over i_inc)
//   o_ptr - current pointer value
module pipe_wrap_ptr #(
    parameter int DEPTH = 2,
    parameter int PW    = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_inc,
    input  logic          i_clr,
    output logic [PW-1:0] o_ptr
);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_next;

    assign w_next = (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    assign o_ptr  = r_ptr;

    always_ff @(posedge clk) begin
        if (!reset)
            r_ptr <= '0;
        else if (i_clr)
            r_ptr <= '0;
        else if (i_inc)
            r_ptr <= w_next;
    end

endmodule

// File: rtl/pipe_elastic_reg.sv
// pipe_elastic_reg: DEPTH-entry elastic pipeline-stage register with valid/ready.
//   clk        - clock, all state updates on posedge
//   reset      - synchronous active-low reset, clears all state
//   ctrl       - stage control: 00 RUN, 01 FLUSH, 10/11 HOLD
//   in_valid   - upstream payload present
//   in_ready   - buffer accepts a payload this cycle (registered state only)
//   in_data    - upstream payload
//   out_valid  - head payload available downstream
//   out_ready  - downstream consumes the head
//   out_data   - head payload, zero when empty
//   occupancy  - number of stored entries
// Optional (macro PIPE_ELASTIC_REG_PERF_EN):
//   hold_cycles - saturating count of HOLD cycles
//   flush_count - saturating count of FLUSH cycles
module pipe_elastic_reg
    import pipe_elastic_reg_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   ctrl,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef PIPE_ELASTIC_REG_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0]        hold_cycles,
    output logic [PERF_CNT_W-1:0]        flush_count
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = ptr_width(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    w_rd;
    logic [PW-1:0]    w_wr;
    pipe_ctrl_t       w_ctrl;
    logic             w_run;
    logic             w_flush;
    logic             w_push;
    logic             w_pop;

    assign w_ctrl  = pipe_ctrl_t'(ctrl);
    assign w_run   = (w_ctrl == PIPE_RUN);
    assign w_flush = (w_ctrl == PIPE_FLUSH);

    // in_ready looks only at stored count, so a full buffer refuses a push
    // even when the head is popped in the same cycle.
    assign in_ready  = (r_count < FULL) && w_run;
    assign out_valid = (r_count != '0) && w_run;
    assign out_data  = (r_count != '0) ? r_mem[w_rd] : '0;
    assign occupancy = r_count;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    pipe_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_pop),
        .i_clr (w_flush),
        .o_ptr (w_rd)
    );

    pipe_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_push),
        .i_clr (w_flush),
        .o_ptr (w_wr)
    );

    always_ff @(posedge clk) begin
        if (!reset)
            r_count <= '0;
        else if (w_flush)
            r_count <= '0;
        else if (w_push && !w_pop)
            r_count <= r_count + 1'b1;
        else if (w_pop && !w_push)
            r_count <= r_count - 1'b1;
    end

    // Flush zeroes the old head so a stale payload never reappears at out_data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_flush) begin
            r_mem[w_rd] <= '0;
        end else if (w_push) begin
            r_mem[w_wr] <= in_data;
        end
    end

`ifdef PIPE_ELASTIC_REG_PERF_EN
    logic [PERF_CNT_W-1:0] r_hold_cycles;
    logic [PERF_CNT_W-1:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hold_cycles <= '0;
            r_flush_count <= '0;
        end else begin
            if (ctrl[1] && (r_hold_cycles != '1))
                r_hold_cycles <= r_hold_cycles + 1'b1;
            if (w_flush && (r_flush_count != '1))
                r_flush_count <= r_flush_count + 1'b1;
        end
    end

    assign hold_cycles = r_hold_cycles;
    assign flush_count = r_flush_count;
`endif

endmodule

// File: doc/pipe_elastic_reg.md
Name: pipe_elastic_reg

Overview:
- Parametrised pipeline-stage register; next generation of the single-entry stage registers between pipeline stages.
- Adds a DEPTH-entry elastic buffer with a valid/ready handshake on both sides.
- Keeps the 2-bit stage control: run, flush, hold.
- Sits between any two pipeline stages; DEPTH=1 behaves as a plain stage register with backpressure.

Parameters:
- WIDTH, 64, payload width in bits (the stage data struct is packed into this).
- DEPTH, 2, number of buffer entries; must be at least 1; need not be a power of two.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset; 0 at a posedge clears all state.
- ctrl  input  2  stage control: 00 RUN, 01 FLUSH, 10 HOLD, 11 HOLD.
- in_valid  input  1  upstream has a payload.
- in_ready  output  1  buffer accepts a payload this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  head payload available to downstream.
- out_ready  input  1  downstream consumes the head this cycle.
- out_data  output  WIDTH  head payload.
- occupancy  output  $clog2(DEPTH+1)  number of stored entries.

Behaviour:
- Storage is a circular buffer with read pointer, write pointer and count (0..DEPTH).
- Pointers wrap from DEPTH-1 to 0.
- Pointer width is max(1,$clog2(DEPTH)).
- in_ready = (count < DEPTH) && ctrl==RUN.
  - Purely registered; in_ready never depends combinationally on out_ready. A full buffer refuses a push even if a pop occurs in the same cycle.
- out_valid = (count != 0) && ctrl==RUN.
- out_data = entry at read pointer when count != 0, otherwise all zeros. It is stable during HOLD.
- Push = in_valid && in_ready: write in_data at the write pointer, advance it.
- Pop = out_valid && out_ready: advance the read pointer.
- Push and pop in the same cycle: both take effect; count unchanged.
- Latency: a payload pushed at edge N is presented with out_valid at cycle N+1 (if ctrl==RUN).
- FLUSH: on the next edge count, both pointers and the head entry go to 0.
  - No push or pop occurs in a FLUSH cycle.
  - Flush takes priority over in_valid/out_ready.
- HOLD (10 or 11): state is frozen; in_ready=0, out_valid=0, out_data holds the head.
- Reset (reset==0 at posedge): count=0, pointers=0, all entries 0, all optional counters 0.
  - After reset: in_ready=1 (if ctrl==RUN), out_valid=0, out_data=0, occupancy=0.
  - Reset mid-operation discards all stored entries; reset overrides ctrl.
- Full (count==DEPTH): in_ready=0. Empty (count==0): out_valid=0.
- DEPTH=1: alternate-cycle throughput under continuous flow (push, then pop frees the slot).

Optional Feature:
- Macro PIPE_ELASTIC_REG_PERF_EN.
- When defined, two extra outputs exist, each a 32-bit saturating counter, cleared by reset, not cleared by FLUSH:
  - hold_cycles: increments each cycle ctrl is HOLD.
  - flush_count: increments each FLUSH cycle.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared pipes package gets:
  - typedef pipe_ctrl_t (2-bit enum: PIPE_RUN=2'b00, PIPE_FLUSH=2'b01, PIPE_HOLD=2'b10, PIPE_HOLD_ALT=2'b11).
  - a helper constant for the counter width (PERF_CNT_W=32).
- One natural sub-module: pipe_wrap_ptr.
  - Parametrised modulo-DEPTH pointer with inc and clear inputs.
  - Instantiated twice, for the read and write pointers.

Test Plan:
- Reset: hold reset=0 two cycles with in_valid=1 -> out_valid=0, occupancy=0, out_data=0. After release with ctrl=00: in_ready=1.
- Fill, DEPTH=2: push 0xA1 then 0xB2 with out_ready=0 -> occupancy 2, in_ready=0, out_data=0xA1. Then out_ready=1 for two cycles -> 0xA1, then 0xB2, then out_valid=0.
- Streaming: continuous in_valid and out_ready with values 1..8 -> outputs 1..8 in order, one cycle after push; occupancy stays 1; wrap-around exercised.
- Flush: buffer holding 0x11 and 0x22, ctrl=01 for one cycle with in_valid=1 -> next cycle occupancy=0, out_data=0, 0x33 offered at the flush not stored.
- Hold: buffer holding 0x55, ctrl=10 for three cycles with out_ready=1 -> out_valid=0, occupancy=1, out_data=0x55. Back to RUN -> 0x55 is popped.
- Perf (macro defined): 3 HOLD cycles plus 2 FLUSH cycles -> hold_cycles=3, flush_count=2; a reset pulse clears both to 0.
